// File: rtl/tcdm_traffic_pkg.sv
// Shared types and constants for the TCDM traffic generator.
package tcdm_traffic_pkg;

   typedef enum logic [1:0] {
      UNIFORM  = 2'd0,
      LINEAR   = 2'd1,
      CONSTANT = 2'd2,
      LIN_RAND = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [31:0] LfsrPoly        = 32'h8020_0003;
   localparam int unsigned CntWidthDefault = 32;

   // An all-zero seed would lock the LFSR, so fall back to 1.
   function automatic logic [31:0] eff_seed(input logic [31:0] seed, input logic [31:0] id);
      logic [31:0] s;
      s = seed ^ id;
      return (s == 32'd0) ? 32'd1 : s;
   endfunction

endpackage

// File: rtl/tcdm_lfsr32.sv
// 32-bit Galois LFSR; loads its seed on reset and steps when enabled.
module tcdm_lfsr32
   import tcdm_traffic_pkg::*;
#(
   parameter logic [31:0] Seed = 32'h0000_0001
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   output logic [31:0] state_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_o <= Seed;
      end else if (en_i) begin
         state_o <= (state_o >> 1) ^ (state_o[0] ? LfsrPoly : 32'd0);
      end
   end

endmodule

// File: rtl/tcdm_traffic_gen.sv
// Per-master TCDM traffic source with req/gnt/wait statistics.
// Optional response checker (err_o) enabled by TCDM_TRAFFIC_GEN_RESP_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start_i after reset
// RUN   | issuing requests until the cycle budget expires and nothing is pending
// DRAIN | one cycle for the last response to return
// DONE  | finished; start_i re-arms a new run
module tcdm_traffic_gen
   import tcdm_traffic_pkg::*;
#(
   parameter int unsigned DataWidth   = 32,
   parameter int unsigned AddrWidth   = 32,
   parameter int unsigned WordIdxBits = 12,
   parameter int unsigned CntWidth    = CntWidthDefault,
   parameter int unsigned MasterId    = 0,
   parameter logic [31:0] Seed        = 32'hDEAD_BEEF
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [1:0]             mode_i,
   input  logic [8:0]             p_req_i,
   input  logic [7:0]             max_len_i,
   input  logic [WordIdxBits-1:0] base_i,
   input  logic                   allow_wr_i,
   input  logic [CntWidth-1:0]    num_cycles_i,
   output logic                   req_o,
   output logic [AddrWidth-1:0]   add_o,
   output logic                   wen_o,
   output logic [DataWidth-1:0]   wdata_o,
   output logic [DataWidth/8-1:0] be_o,
   input  logic                   gnt_i,
   input  logic                   vld_i,
   input  logic [DataWidth-1:0]   rdata_i,
`ifdef TCDM_TRAFFIC_GEN_RESP_CHECK_EN
   output logic                   err_o,
`endif
   output logic                   busy_o,
   output logic                   done_o,
   output logic [CntWidth-1:0]    req_cnt_o,
   output logic [CntWidth-1:0]    gnt_cnt_o,
   output logic [CntWidth-1:0]    wait_cnt_o
);

   localparam int unsigned OffBits = $clog2(DataWidth / 8);
   localparam logic [31:0] EffSeed = eff_seed(Seed, 32'(MasterId));

   state_e                 state_q, state_d;
   mode_e                  mode_q;
   logic [8:0]             p_req_q;
   logic [7:0]             max_len_q;
   logic [WordIdxBits-1:0] base_q;
   logic                   allow_wr_q;
   logic [CntWidth-1:0]    cycles_left_q;
   logic [WordIdxBits-1:0] cur_idx_q;
   logic [7:0]             burst_left_q;
   logic [31:0]            lfsr;

   logic                   start_ok, granted, slot_free, run_end, issue, new_burst;
   logic [WordIdxBits-1:0] rand_idx, idx_inc, idx_sel;
   logic [7:0]             burst_dec, max_len_eff, burst_len;
   logic [AddrWidth-1:0]   add_nxt;
   logic [DataWidth-1:0]   wdata_nxt;

   tcdm_lfsr32 #(.Seed(EffSeed)) i_lfsr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (state_q == RUN),
      .state_o (lfsr)
   );

   assign start_ok  = start_i && ((state_q == IDLE) || (state_q == DONE));
   assign granted   = req_o & gnt_i;
   assign slot_free = ~req_o | gnt_i;
   assign run_end   = (cycles_left_q == '0);
   assign issue     = (state_q == RUN) && slot_free && !run_end &&
                      ({1'b0, lfsr[7:0]} < p_req_q);
   assign busy_o    = (state_q == RUN) || (state_q == DRAIN);
   assign done_o    = (state_q == DONE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: if (start_i) state_d = RUN;
         RUN:        if (run_end && slot_free) state_d = DRAIN;
         DRAIN:      state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   // Index/burst bookkeeping first accounts for a grant in this cycle, then
   // picks the index of the request that would be issued on the next edge.
   always_comb begin
      rand_idx  = '0;
      wdata_nxt = '0;
      for (int i = 0; i < int'(WordIdxBits); i++) rand_idx[i] = lfsr[(i + 8) % 32];
      for (int i = 0; i < int'(DataWidth); i++)   wdata_nxt[i] = lfsr[i % 32];
      idx_inc     = cur_idx_q + WordIdxBits'(granted);
      burst_dec   = burst_left_q - 8'((granted && (burst_left_q != 8'd0)) ? 1 : 0);
      new_burst   = (burst_dec == 8'd0);
      max_len_eff = (max_len_q == 8'd0) ? 8'd1 : max_len_q;
      burst_len   = (lfsr[31:24] % max_len_eff) + 8'd1;
      unique case (mode_q)
         UNIFORM:  idx_sel = rand_idx;
         LINEAR:   idx_sel = idx_inc;
         CONSTANT: idx_sel = base_q;
         default:  idx_sel = new_burst ? rand_idx : idx_inc;
      endcase
      add_nxt = '0;
      add_nxt[OffBits +: WordIdxBits] = idx_sel;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q        <= UNIFORM;
         p_req_q       <= '0;
         max_len_q     <= '0;
         base_q        <= '0;
         allow_wr_q    <= 1'b0;
         cycles_left_q <= '0;
         cur_idx_q     <= '0;
         burst_left_q  <= '0;
         req_o         <= 1'b0;
         add_o         <= '0;
         wen_o         <= 1'b0;
         wdata_o       <= '0;
         be_o          <= '0;
         req_cnt_o     <= '0;
         gnt_cnt_o     <= '0;
         wait_cnt_o    <= '0;
      end else if (start_ok) begin
         mode_q        <= mode_e'(mode_i);
         p_req_q       <= p_req_i;
         max_len_q     <= max_len_i;
         base_q        <= base_i;
         allow_wr_q    <= allow_wr_i;
         cycles_left_q <= num_cycles_i;
         cur_idx_q     <= base_i;
         burst_left_q  <= '0;
         req_o         <= 1'b0;
         req_cnt_o     <= '0;
         gnt_cnt_o     <= '0;
         wait_cnt_o    <= '0;
      end else begin
         if (req_o && (req_cnt_o != '1))               req_cnt_o  <= req_cnt_o + CntWidth'(1);
         if (granted && (gnt_cnt_o != '1))             gnt_cnt_o  <= gnt_cnt_o + CntWidth'(1);
         if (req_o && !gnt_i && (wait_cnt_o != '1))    wait_cnt_o <= wait_cnt_o + CntWidth'(1);
         if (state_q == RUN) begin
            if (!run_end)  cycles_left_q <= cycles_left_q - CntWidth'(1);
            if (slot_free) req_o <= issue;
            if (issue) begin
               add_o   <= add_nxt;
               wen_o   <= allow_wr_q & lfsr[31];
               wdata_o <= wdata_nxt;
               be_o    <= '1;
            end
            if (issue && (mode_q == LIN_RAND) && new_burst) begin
               cur_idx_q    <= rand_idx;
               burst_left_q <= burst_len;
            end else begin
               cur_idx_q    <= idx_inc;
               burst_left_q <= burst_dec;
            end
         end
      end
   end

`ifdef TCDM_TRAFFIC_GEN_RESP_CHECK_EN
   logic granted_q;
   logic unused_resp;
   assign unused_resp = ^rdata_i;

   // Responses must arrive exactly one cycle after each grant, never otherwise.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         granted_q <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         granted_q <= granted;
         if (start_ok)                err_o <= 1'b0;
         else if (granted_q != vld_i) err_o <= 1'b1;
      end
   end
`else
   logic unused_resp;
   assign unused_resp = vld_i ^ (^rdata_i);
`endif

endmodule

// File: tb/tb_tcdm_traffic_gen.sv
// Directed bench for tcdm_traffic_gen; response-check tests run when
// TCDM_TRAFFIC_GEN_RESP_CHECK_EN is defined.
module tb_tcdm_traffic_gen;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [1:0]  mode_i = 2'd0;
   logic [8:0]  p_req_i = 9'd0;
   logic [7:0]  max_len_i = 8'd0;
   logic [11:0] base_i = 12'd0;
   logic        allow_wr_i = 1'b0;
   logic [31:0] num_cycles_i = 32'd0;
   logic        req_o, wen_o, gnt_i, vld_i, busy_o, done_o;
   logic [31:0] add_o, wdata_o, rdata_i, req_cnt_o, gnt_cnt_o, wait_cnt_o;
   logic [3:0]  be_o;
`ifdef TCDM_TRAFFIC_GEN_RESP_CHECK_EN
   logic        err_o;
`endif

   int checks = 0;
   int errors = 0;
   int done_at;
   logic [31:0] addr_q[$];
   logic [31:0] data_q[$];
   logic        wen_q[$];

   logic       vld_d1 = 1'b0, vld_d2 = 1'b0;
   logic [1:0] vld_sel = 2'd0;

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      vld_d1 <= req_o & gnt_i;
      vld_d2 <= vld_d1;
   end
   assign vld_i   = (vld_sel == 2'd1) ? vld_d1 : (vld_sel == 2'd2) ? vld_d2 : 1'b0;
   assign rdata_i = 32'd0;

   tcdm_traffic_gen dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .mode_i       (mode_i),
      .p_req_i      (p_req_i),
      .max_len_i    (max_len_i),
      .base_i       (base_i),
      .allow_wr_i   (allow_wr_i),
      .num_cycles_i (num_cycles_i),
      .req_o        (req_o),
      .add_o        (add_o),
      .wen_o        (wen_o),
      .wdata_o      (wdata_o),
      .be_o         (be_o),
      .gnt_i        (gnt_i),
      .vld_i        (vld_i),
      .rdata_i      (rdata_i),
`ifdef TCDM_TRAFFIC_GEN_RESP_CHECK_EN
      .err_o        (err_o),
`endif
      .busy_o       (busy_o),
      .done_o       (done_o),
      .req_cnt_o    (req_cnt_o),
      .gnt_cnt_o    (gnt_cnt_o),
      .wait_cnt_o   (wait_cnt_o)
   );

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset;
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic do_start(input logic [1:0] m, input logic [8:0] p, input logic [7:0] ml,
                           input logic [11:0] b, input logic wr, input logic [31:0] n);
      mode_i = m; p_req_i = p; max_len_i = ml; base_i = b; allow_wr_i = wr; num_cycles_i = n;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   // Steps until done_o or budget; logs every requesting cycle.
   task automatic run_collect(input int budget);
      addr_q.delete(); data_q.delete(); wen_q.delete();
      done_at = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (req_o) begin
            addr_q.push_back(add_o);
            data_q.push_back(wdata_o);
            wen_q.push_back(wen_o);
         end
         if (done_o) begin
            done_at = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      do_reset();
      checks++; if (req_o !== 1'b0)      begin errors++; $display("FAIL reset_req got %0h exp 0", req_o); end
      checks++; if (add_o !== 32'd0)     begin errors++; $display("FAIL reset_add got %0h exp 0", add_o); end
      checks++; if (busy_o !== 1'b0 || done_o !== 1'b0)
         begin errors++; $display("FAIL reset_state got busy %0h done %0h exp 0 0", busy_o, done_o); end
      checks++; if (req_cnt_o !== 32'd0 || gnt_cnt_o !== 32'd0 || wait_cnt_o !== 32'd0)
         begin errors++; $display("FAIL reset_cnt got %0h %0h %0h exp 0 0 0", req_cnt_o, gnt_cnt_o, wait_cnt_o); end
   endtask

   // First run after reset: LFSR starts at the seed.
   task automatic test_uniform_write;
      logic [31:0] s0, s1;
      s0 = 32'hDEAD_BEEF;
      s1 = lfsr_next(s0);
      gnt_i = 1'b1;
      do_start(2'd0, 9'd256, 8'd0, 12'd0, 1'b1, 32'd2);
      run_collect(20);
      checks++; if (done_at !== 4)  begin errors++; $display("FAIL uni_done_at got %0d exp 4", done_at); end
      checks++; if (addr_q.size() !== 2) begin errors++; $display("FAIL uni_nreq got %0d exp 2", addr_q.size()); end
      if (addr_q.size() == 2) begin
         checks++; if (addr_q[0] !== {18'd0, s0[19:8], 2'b00})
            begin errors++; $display("FAIL uni_add0 got %0h exp %0h", addr_q[0], {18'd0, s0[19:8], 2'b00}); end
         checks++; if (addr_q[1] !== {18'd0, s1[19:8], 2'b00})
            begin errors++; $display("FAIL uni_add1 got %0h exp %0h", addr_q[1], {18'd0, s1[19:8], 2'b00}); end
         checks++; if (data_q[0] !== s0) begin errors++; $display("FAIL uni_wdata0 got %0h exp %0h", data_q[0], s0); end
         checks++; if (data_q[1] !== s1) begin errors++; $display("FAIL uni_wdata1 got %0h exp %0h", data_q[1], s1); end
         checks++; if (wen_q[0] !== s0[31] || wen_q[1] !== s1[31])
            begin errors++; $display("FAIL uni_wen got %0h %0h exp %0h %0h", wen_q[0], wen_q[1], s0[31], s1[31]); end
      end
      checks++; if (be_o !== 4'hF) begin errors++; $display("FAIL uni_be got %0h exp f", be_o); end
   endtask

   task automatic test_constant;
      int bad;
      gnt_i = 1'b1;
      do_start(2'd2, 9'd256, 8'd0, 12'd5, 1'b0, 32'd10);
      run_collect(40);
      bad = 0;
      foreach (addr_q[i]) if (addr_q[i] !== 32'h14 || wen_q[i] !== 1'b0) bad++;
      checks++; if (done_at !== 12) begin errors++; $display("FAIL const_done_at got %0d exp 12", done_at); end
      checks++; if (addr_q.size() !== 10) begin errors++; $display("FAIL const_nreq got %0d exp 10", addr_q.size()); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL const_add got %0d bad exp 0 bad", bad); end
      checks++; if (req_cnt_o !== 32'd10 || gnt_cnt_o !== 32'd10 || wait_cnt_o !== 32'd0)
         begin errors++; $display("FAIL const_cnt got %0d %0d %0d exp 10 10 0", req_cnt_o, gnt_cnt_o, wait_cnt_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL const_busy got %0h exp 0", busy_o); end
   endtask

   task automatic test_linear;
      logic [31:0] exp_add [4];
      exp_add = '{32'h3FF8, 32'h3FFC, 32'h0000, 32'h0004};
      gnt_i = 1'b1;
      do_start(2'd1, 9'd256, 8'd0, 12'd4094, 1'b0, 32'd4);
      run_collect(20);
      checks++; if (done_at !== 6) begin errors++; $display("FAIL lin_done_at got %0d exp 6", done_at); end
      checks++; if (addr_q.size() !== 4) begin errors++; $display("FAIL lin_nreq got %0d exp 4", addr_q.size()); end
      if (addr_q.size() == 4)
         for (int i = 0; i < 4; i++) begin
            checks++; if (addr_q[i] !== exp_add[i])
               begin errors++; $display("FAIL lin_add%0d got %0h exp %0h", i, addr_q[i], exp_add[i]); end
         end
   endtask

   task automatic test_hold;
      logic [31:0] a0, d0;
      logic        w0;
      gnt_i = 1'b0;
      do_start(2'd2, 9'd256, 8'd0, 12'd100, 1'b1, 32'd1);
      tick();
      a0 = add_o; d0 = wdata_o; w0 = wen_o;
      checks++; if (req_o !== 1'b1 || add_o !== 32'h190)
         begin errors++; $display("FAIL hold_first got req %0h add %0h exp 1 190", req_o, add_o); end
      for (int k = 2; k <= 4; k++) begin
         tick();
         checks++; if (req_o !== 1'b1 || add_o !== a0 || wdata_o !== d0 || wen_o !== w0 || be_o !== 4'hF)
            begin errors++; $display("FAIL hold_stable%0d got req %0h add %0h data %0h exp 1 %0h %0h", k, req_o, add_o, wdata_o, a0, d0); end
      end
      gnt_i = 1'b1;
      tick();
      checks++; if (req_o !== 1'b0 || busy_o !== 1'b1)
         begin errors++; $display("FAIL hold_drain got req %0h busy %0h exp 0 1", req_o, busy_o); end
      tick();
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL hold_done got %0h exp 1", done_o); end
      checks++; if (req_cnt_o !== 32'd4 || gnt_cnt_o !== 32'd1 || wait_cnt_o !== 32'd3)
         begin errors++; $display("FAIL hold_cnt got %0d %0d %0d exp 4 1 3", req_cnt_o, gnt_cnt_o, wait_cnt_o); end
   endtask

   task automatic test_never;
      gnt_i = 1'b1;
      do_start(2'd0, 9'd0, 8'd0, 12'd0, 1'b1, 32'd100);
      run_collect(150);
      checks++; if (done_at !== 102) begin errors++; $display("FAIL never_done_at got %0d exp 102", done_at); end
      checks++; if (addr_q.size() !== 0) begin errors++; $display("FAIL never_nreq got %0d exp 0", addr_q.size()); end
      checks++; if (req_cnt_o !== 32'd0 || gnt_cnt_o !== 32'd0 || wait_cnt_o !== 32'd0)
         begin errors++; $display("FAIL never_cnt got %0d %0d %0d exp 0 0 0", req_cnt_o, gnt_cnt_o, wait_cnt_o); end
   endtask

   task automatic test_zero_cycles;
      gnt_i = 1'b1;
      do_start(2'd2, 9'd256, 8'd0, 12'd7, 1'b0, 32'd0);
      run_collect(20);
      checks++; if (done_at !== 2) begin errors++; $display("FAIL zero_done_at got %0d exp 2", done_at); end
      checks++; if (addr_q.size() !== 0) begin errors++; $display("FAIL zero_nreq got %0d exp 0", addr_q.size()); end
   endtask

   task automatic test_burst;
      int run_len, bad, n_runs;
      logic [11:0] prev, cur;
      do_reset();
      gnt_i = 1'b1;
      do_start(2'd3, 9'd256, 8'd4, 12'd0, 1'b0, 32'd30);
      run_collect(60);
      checks++; if (done_at !== 32) begin errors++; $display("FAIL burst_done_at got %0d exp 32", done_at); end
      checks++; if (addr_q.size() !== 30) begin errors++; $display("FAIL burst_nreq got %0d exp 30", addr_q.size()); end
      bad = 0; n_runs = 0; run_len = 0; prev = '0;
      foreach (addr_q[i]) begin
         cur = addr_q[i][13:2];
         if (i == 0 || cur != prev + 12'd1) begin
            if (i > 0 && run_len > 4) bad++;
            n_runs++;
            run_len = 1;
         end else begin
            run_len++;
         end
         prev = cur;
      end
      if (run_len > 4) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL burst_len got %0d long runs exp 0", bad); end
      checks++; if (n_runs < 8) begin errors++; $display("FAIL burst_runs got %0d exp at least 8", n_runs); end
   endtask

   task automatic test_reset_mid_run;
      gnt_i = 1'b0;
      do_start(2'd2, 9'd256, 8'd0, 12'd3, 1'b1, 32'd50);
      for (int i = 0; i < 5; i++) tick();
      rst_ni = 1'b0;
      #1;
      checks++; if (req_o !== 1'b0 || add_o !== 32'd0 || wdata_o !== 32'd0)
         begin errors++; $display("FAIL midrst_out got req %0h add %0h data %0h exp 0 0 0", req_o, add_o, wdata_o); end
      checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || wait_cnt_o !== 32'd0 || req_cnt_o !== 32'd0)
         begin errors++; $display("FAIL midrst_state got busy %0h done %0h wait %0d req %0d exp 0", busy_o, done_o, wait_cnt_o, req_cnt_o); end
`ifdef TCDM_TRAFFIC_GEN_RESP_CHECK_EN
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL midrst_err got %0h exp 0", err_o); end
`endif
      tick();
      rst_ni = 1'b1;
      tick();
      tick();
      checks++; if (busy_o !== 1'b0 || req_o !== 1'b0)
         begin errors++; $display("FAIL midrst_idle got busy %0h req %0h exp 0 0", busy_o, req_o); end
      gnt_i = 1'b1;
   endtask

`ifdef TCDM_TRAFFIC_GEN_RESP_CHECK_EN
   task automatic test_resp_check;
      gnt_i = 1'b1;
      vld_sel = 2'd1;
      do_start(2'd2, 9'd256, 8'd0, 12'd1, 1'b0, 32'd5);
      run_collect(20);
      tick();
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL resp_ok got %0h exp 0", err_o); end
      vld_sel = 2'd2;
      do_start(2'd2, 9'd256, 8'd0, 12'd1, 1'b0, 32'd1);
      run_collect(20);
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL resp_late got %0h exp 1", err_o); end
      for (int i = 0; i < 3; i++) tick();
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL resp_sticky got %0h exp 1", err_o); end
      vld_sel = 2'd1;
      do_start(2'd2, 9'd256, 8'd0, 12'd1, 1'b0, 32'd3);
      run_collect(20);
      tick();
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL resp_clear got %0h exp 0", err_o); end
   endtask
`endif

   initial begin
      gnt_i = 1'b1;
      test_reset();
      test_uniform_write();
      test_constant();
      test_linear();
      test_hold();
      test_never();
      test_zero_cycles();
      test_reset_mid_run();
      test_burst();
`ifdef TCDM_TRAFFIC_GEN_RESP_CHECK_EN
      test_resp_check();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of tests");
      $fatal(1);
   end

endmodule
